// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - MEM-to-WB stage bus: result sources in, registered write-back out.
interface wb_stage_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              stall;
   logic              flush;
   logic [1:0]        wb_sel;
   logic [2:0]        load_type;
   logic [1:0]        byte_off;
   logic [DATA_W-1:0] readData;
   logic [DATA_W-1:0] ALUResult;
   logic [DATA_W-1:0] pc_plus4;
   logic [DATA_W-1:0] imm_upper;
   logic [REG_AW-1:0] rd;
   logic              reg_write;

   logic [DATA_W-1:0] writeData;
   logic [REG_AW-1:0] writeReg;
   logic              regWrite_out;
   logic              wb_valid;
   logic              align_err;
   logic [CNT_W-1:0]  retire_count;

   modport master (
      output in_valid, stall, flush, wb_sel, load_type, byte_off,
             readData, ALUResult, pc_plus4, imm_upper, rd, reg_write,
      input  writeData, writeReg, regWrite_out, wb_valid, align_err, retire_count
   );

   modport slave (
      input  in_valid, stall, flush, wb_sel, load_type, byte_off,
             readData, ALUResult, pc_plus4, imm_upper, rd, reg_write,
      output writeData, writeReg, regWrite_out, wb_valid, align_err, retire_count
   );
endinterface

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - Write-back pipeline register with load extraction and retire counter.
module wb_stage_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst_n,
   wb_stage_pipe_if.slave  bus
);

   logic [31:0]       lo32;
   logic [15:0]       half;
   logic [7:0]        byte_v;
   logic [DATA_W-1:0] load_val;
   logic [DATA_W-1:0] result;
   logic              align_bad;
   logic              align_cond;

   logic [DATA_W-1:0] data_q;
   logic [REG_AW-1:0] reg_q;
   logic              we_q;
   logic              valid_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   // Loads only ever look at the low word, even on a 64-bit datapath.
   always_comb begin
      lo32      = bus.readData[31:0];
      half      = bus.byte_off[1] ? lo32[31:16] : lo32[15:0];
      byte_v    = lo32[{bus.byte_off, 3'b000} +: 8];
      load_val  = '0;
      align_bad = 1'b0;
      case (bus.load_type)
         3'd0: begin
            load_val  = DATA_W'(lo32);
            align_bad = (bus.byte_off != 2'd0);
         end
         3'd1: begin
            load_val  = DATA_W'($signed(half));
            align_bad = bus.byte_off[0];
         end
         3'd2: begin
            load_val  = DATA_W'(half);
            align_bad = bus.byte_off[0];
         end
         3'd3: load_val = DATA_W'($signed(byte_v));
         3'd4: load_val = DATA_W'(byte_v);
         default: align_bad = 1'b1;
      endcase
   end

   always_comb begin
      align_cond = (bus.wb_sel == 2'd1) && align_bad;
      result     = '0;
      case (bus.wb_sel)
         2'd0: result = bus.ALUResult;
         2'd1: result = align_cond ? '0 : load_val;
         2'd2: result = bus.pc_plus4;
         default: result = bus.imm_upper;
      endcase
   end

   // Flush kills only the control bits; data fields keep their last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         reg_q   <= '0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else if (!bus.stall) begin
         valid_q <= bus.in_valid;
         data_q  <= result;
         reg_q   <= bus.rd;
         we_q    <= bus.reg_write & bus.in_valid & ~align_cond & (bus.rd != '0);
         err_q   <= bus.in_valid & align_cond;
         if (bus.in_valid)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.writeData    = data_q;
   assign bus.writeReg     = reg_q;
   assign bus.regWrite_out = we_q;
   assign bus.wb_valid     = valid_q;
   assign bus.align_err    = err_q;
   assign bus.retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - Directed bench with a cycle model of the WB stage and literal pins.
module tb_wb_stage_pipe;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   run = 1'b0;
   int   total = 0;
   int   bad = 0;

   wb_stage_pipe_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();
   wb_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Result expected from the load/select rules, done with plain shifts and masks.
   function automatic logic [31:0] model_result(input int sel, input int lt, input int off,
         input logic [31:0] rdata, input logic [31:0] alu, input logic [31:0] pc,
         input logic [31:0] imm, output bit err);
      logic [31:0] v;
      logic [31:0] piece;
      err = 0;
      v   = 0;
      if (sel == 0) v = alu;
      else if (sel == 2) v = pc;
      else if (sel == 3) v = imm;
      else begin
         if (lt == 0) begin
            err = (off != 0);
            v   = rdata;
         end else if (lt == 1 || lt == 2) begin
            err   = (off % 2) != 0;
            piece = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            v     = (lt == 1 && piece >= 32'h8000) ? (piece | 32'hFFFF_0000) : piece;
         end else if (lt == 3 || lt == 4) begin
            piece = (rdata >> (8 * off)) & 32'hFF;
            v     = (lt == 3 && piece >= 32'h80) ? (piece | 32'hFFFF_FF00) : piece;
         end else err = 1;
         if (err) v = 0;
      end
      return v;
   endfunction

   logic [31:0] m_wd = 0;
   logic [4:0]  m_wr = 0;
   bit          m_we = 0, m_v = 0, m_ae = 0;
   int          m_cnt = 0;

   always @(posedge clk or negedge rst_n) begin
      bit          e;
      logic [31:0] r;
      if (!rst_n) begin
         m_wd = 0; m_wr = 0; m_we = 0; m_v = 0; m_ae = 0; m_cnt = 0;
      end else if (bus.flush) begin
         m_v = 0; m_we = 0; m_ae = 0;
      end else if (!bus.stall) begin
         r = model_result(int'(bus.wb_sel), int'(bus.load_type), int'(bus.byte_off),
                          bus.readData, bus.ALUResult, bus.pc_plus4, bus.imm_upper, e);
         m_wd = r;
         m_wr = bus.rd;
         m_v  = bus.in_valid;
         m_ae = bus.in_valid && e;
         m_we = bus.in_valid && bus.reg_write && !e && (bus.rd != 0);
         if (bus.in_valid) m_cnt = (m_cnt + 1) % (1 << CW);
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("cmp_writeData", bus.writeData, m_wd);
         chk("cmp_writeReg", 32'(bus.writeReg), 32'(m_wr));
         chk("cmp_regWrite", 32'(bus.regWrite_out), 32'(m_we));
         chk("cmp_wb_valid", 32'(bus.wb_valid), 32'(m_v));
         chk("cmp_align_err", 32'(bus.align_err), 32'(m_ae));
         chk("cmp_retire", 32'(bus.retire_count), 32'(m_cnt));
      end
   end

   task automatic drive(input bit v, input bit st, input bit fl, input logic [1:0] sel,
         input logic [2:0] lt, input logic [1:0] off, input logic [31:0] rdata,
         input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
         input logic [4:0] r, input bit rw);
      bus.in_valid  = v;   bus.stall    = st;  bus.flush     = fl;
      bus.wb_sel    = sel; bus.load_type = lt; bus.byte_off  = off;
      bus.readData  = rdata; bus.ALUResult = alu; bus.pc_plus4 = pc;
      bus.imm_upper = imm; bus.rd = r; bus.reg_write = rw;
      @(posedge clk);
      #2;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] wd, input logic [4:0] wr,
         input bit we, input bit v, input bit ae, input int cnt);
      chk({tag, "_writeData"}, bus.writeData, wd);
      chk({tag, "_writeReg"}, 32'(bus.writeReg), 32'(wr));
      chk({tag, "_regWrite"}, 32'(bus.regWrite_out), 32'(we));
      chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 32'(v));
      chk({tag, "_align_err"}, 32'(bus.align_err), 32'(ae));
      chk({tag, "_retire"}, 32'(bus.retire_count), 32'(cnt));
   endtask

   localparam logic [31:0] RD = 32'h80FF_7F01;

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      run   = 1'b1;

      drive(1, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 5, 1);
      chk_all("alu", 32'h1234, 5, 1, 1, 0, 1);
      drive(1, 0, 0, 1, 3, 2, RD, 0, 0, 0, 6, 1);
      chk("lb_off2", bus.writeData, 32'hFFFF_FFFF);
      drive(1, 0, 0, 1, 4, 3, RD, 0, 0, 0, 6, 1);
      chk("lbu_off3", bus.writeData, 32'h0000_0080);
      drive(1, 0, 0, 1, 1, 2, RD, 0, 0, 0, 6, 1);
      chk("lh_off2", bus.writeData, 32'hFFFF_80FF);
      drive(1, 0, 0, 1, 2, 0, RD, 0, 0, 0, 6, 1);
      chk("lhu_off0", bus.writeData, 32'h0000_7F01);
      drive(1, 0, 0, 1, 1, 1, RD, 0, 0, 0, 6, 1);
      chk_all("lh_misalign", 0, 6, 0, 1, 1, 6);
      drive(1, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 7, 1);
      chk_all("lw", 32'hDEAD_BEEF, 7, 1, 1, 0, 7);
      drive(1, 0, 0, 1, 5, 0, RD, 0, 0, 0, 7, 1);
      chk_all("reserved_lt", 0, 7, 0, 1, 1, 8);
      drive(1, 0, 0, 2, 0, 0, 0, 0, 32'h104, 0, 1, 1);
      chk_all("link", 32'h104, 1, 1, 1, 0, 9);

      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 3, 0, 0, 0, 0, 0, 32'hABCD_0000, 9, 1);
         chk_all("stall", 32'h104, 1, 1, 1, 0, 9);
      end
      drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 32'hABCD_0000, 9, 1);
      chk_all("flush", 32'h104, 1, 0, 0, 0, 9);
      drive(0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 3, 1);
      chk_all("bubble", 32'h55, 3, 0, 0, 0, 9);
      drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 32'h1234_5000, 0, 1);
      chk_all("rd0", 32'h1234_5000, 0, 0, 1, 0, 10);

      for (int i = 0; i < 7; i++)
         drive(1, 0, 0, 0, 0, 0, 0, 32'(i), 0, 0, 2, 1);
      chk("wrap17", 32'(bus.retire_count), 32'd1);

      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0, 32'h77, 0, 0, 4, 1);
      chk_all("post_rst", 32'h77, 4, 1, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/wb_stage_pipe.md
WB_STAGE_PIPE -- requirements
Module: wb_stage_pipe

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, datapath width; legal values 32 and 64.
REQ-002 The block SHALL take parameter REG_AW, default 5, register-index width.
REQ-003 The block SHALL take parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  MEM-stage result present
- stall  in  1  hold WB register contents
- flush  in  1  kill WB register contents
- wb_sel  in  2  result source: 0 ALUResult, 1 readData (load), 2 pc_plus4 (link), 3 imm_upper
- load_type  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 reserved
- byte_off  in  2  load address bits [1:0]
- readData  in  DATA_W  memory read word
- ALUResult  in  DATA_W  ALU result
- pc_plus4  in  DATA_W  link address
- imm_upper  in  DATA_W  upper-immediate value
- rd  in  REG_AW  destination register
- reg_write  in  1  instruction writes the register file
- writeData  out  DATA_W  registered write-back value
- writeReg  out  REG_AW  registered destination
- regWrite_out  out  1  registered register-file write enable
- wb_valid  out  1  a retired instruction occupies WB
- align_err  out  1  misaligned load or reserved load_type seen in WB
- retire_count  out  CNT_W  retired-instruction count

Function
REQ-005 The block SHALL capture in_valid and the computed result into the WB register on the rising clk edge; latency is exactly 1 cycle from input to output.
REQ-006 Per-edge priority: flush, then stall, then load.
- flush=1: wb_valid<=0, regWrite_out<=0, align_err<=0; data fields hold.
- stall=1: all WB outputs hold.
- otherwise: wb_valid<=in_valid; remaining fields load from inputs.
REQ-007 With wb_sel=0, 2 or 3 the block SHALL select ALUResult, pc_plus4 or imm_upper unchanged.
REQ-008 With wb_sel=1 the block SHALL extract little-endian from the low 32 bits of readData; for DATA_W=64, LW zero-extends.
- LW: byte_off must be 0.
- LH/LHU: halfword at byte_off[1]*16, sign-/zero-extended; byte_off[0] must be 0.
- LB/LBU: byte at byte_off*8, sign-/zero-extended.
REQ-009 A misaligned or reserved-type load with in_valid=1 SHALL load align_err=1, regWrite_out=0, writeData=0; wb_valid=1 and the instruction still counts as retired.
REQ-010 regWrite_out SHALL load reg_write & in_valid & ~align_condition & (rd != 0); writes to register 0 are suppressed.
REQ-011 retire_count SHALL increment by 1 on each edge where wb_valid is loaded as 1, i.e. in_valid=1, stall=0 and flush=0.
REQ-012 retire_count SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-013 A stall lasting N cycles SHALL retire nothing and leave retire_count unchanged.
REQ-014 in_valid=0 with stall=0 and flush=0 SHALL load a bubble: wb_valid=0 and regWrite_out=0.
REQ-015 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-016 When rst_n=0, asynchronously and regardless of clk, the block SHALL drive writeData=0, writeReg=0, regWrite_out=0, wb_valid=0, align_err=0 and retire_count=0.
REQ-017 Assertion of rst_n mid-operation SHALL discard the in-flight instruction.
REQ-018 The first capture SHALL occur on the first rising edge after rst_n deasserts.

Verification
REQ-019 ALU path: wb_sel=0, ALUResult=0x0000_1234, rd=5, reg_write=1, in_valid=1 -> next cycle writeData=0x1234, writeReg=5, regWrite_out=1, retire_count=1.
REQ-020 Load extension: readData=0x80FF_7F01.
- LB, byte_off=2 -> writeData=0xFFFF_FFFF.
- LBU, byte_off=3 -> writeData=0x0000_0080.
- LH, byte_off=2 -> writeData=0xFFFF_80FF.
- LHU, byte_off=0 -> writeData=0x0000_7F01.
REQ-021 Misaligned load: LH, byte_off=1 -> align_err=1, regWrite_out=0, wb_valid=1.
REQ-022 Priority: stall=1 for 3 cycles, then flush=1 and stall=1 together.
- During stall: outputs held, count unchanged.
- At flush: wb_valid=0, regWrite_out=0.
REQ-023 Register-0 and wrap: rd=0, reg_write=1 -> regWrite_out=0; with CNT_W=4, 17 retirements -> retire_count=1.
REQ-024 Reset mid-stream: rst_n pulsed low between edges -> all outputs 0 immediately; next valid input -> retire_count=1.
